// File: rtl/rgb_pwm_dimmer.sv
// rgb_pwm_dimmer: PWM brightness stage for one RGB traffic-light head.
//
// The colour (r_in/g_in/b_in) and the brightness (bright) are sampled only at a PWM period
// boundary. The new values take effect from cnt = 0, so no runt pulses appear on the pins.
//
// Optional feature, macro PWM_FADE_EN:
//   defined   - every colour change restarts at level 0 and ramps up by FADE_STEP per period.
//   undefined - a colour change jumps straight to the requested level; fade_busy is tied 0.
//
// Parameters:
//   PWM_W      PWM counter width; period = 2**PWM_W en ticks
//   FADE_STEP  level increment per PWM period while fading (nonzero)
// Ports:
//   clk        system clock
//   rstn       synchronous reset, active-low
//   en         PWM tick strobe; gates all counter and level updates
//   r_in/g_in/b_in  requested colour from the colour decoder
//   bright     target duty level (0 = dark)
//   r_out/g_out/b_out  registered PWM-dimmed LED pins
//   fade_busy  high while a fade-in is in progress
module rgb_pwm_dimmer #(
  parameter int unsigned PWM_W     = 8,
  parameter int unsigned FADE_STEP = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             r_in,
  input  logic             g_in,
  input  logic             b_in,
  input  logic [PWM_W-1:0] bright,
  output logic             r_out,
  output logic             g_out,
  output logic             b_out,
  output logic             fade_busy
);

  typedef enum logic [1:0] {StOff, StFade, StSteady} state_e;

  state_e           state_q, state_d;
  logic [PWM_W-1:0] cnt_q;
  logic [PWM_W-1:0] level_q, level_d;
  logic [PWM_W-1:0] tgt_q;
  logic [2:0]       rgb_q;
  logic [2:0]       nrgb;
  logic             bnd;
  logic             pwm_on;
  logic [PWM_W:0]   ramp_sum;
  logic [PWM_W:0]   ramp_min;

  assign nrgb   = {r_in, g_in, b_in};
  assign bnd    = en & (cnt_q == {PWM_W{1'b1}});
  assign pwm_on = (cnt_q < level_q);

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    // One extra bit so the ramp saturates at the target instead of wrapping.
    ramp_sum = {1'b0, level_q} + (PWM_W + 1)'(FADE_STEP);
    ramp_min = (ramp_sum < {1'b0, bright}) ? ramp_sum : {1'b0, bright};

    if (bnd) begin
      if ((bright == '0) || (nrgb == 3'b000)) begin
        state_d = StOff;
        level_d = '0;
      end else if (nrgb != rgb_q) begin
`ifdef PWM_FADE_EN
        state_d = StFade;
        level_d = '0;
`else
        state_d = StSteady;
        level_d = bright;
`endif
      end else begin
        unique case (state_q)
          // A target below the current level also lands here: min() picks it and we settle.
          StFade: begin
            level_d = ramp_min[PWM_W-1:0];
            state_d = (ramp_min == {1'b0, bright}) ? StSteady : StFade;
          end
          // In steady state level equals the last target, so only a new target moves it.
          StSteady: begin
            level_d = (bright != tgt_q) ? bright : level_q;
          end
          // Dark with the colour unchanged: brightness comes back without a fade.
          default: begin
            state_d = StSteady;
            level_d = bright;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q   <= '0;
      level_q <= '0;
      tgt_q   <= '0;
      rgb_q   <= '0;
      state_q <= StOff;
      r_out   <= 1'b0;
      g_out   <= 1'b0;
      b_out   <= 1'b0;
    end else begin
      if (en) begin
        cnt_q <= cnt_q + 1'b1;
      end
      level_q <= level_d;
      state_q <= state_d;
      if (bnd) begin
        rgb_q <= nrgb;
        tgt_q <= bright;
      end
      r_out <= rgb_q[2] & pwm_on;
      g_out <= rgb_q[1] & pwm_on;
      b_out <= rgb_q[0] & pwm_on;
    end
  end

`ifdef PWM_FADE_EN
  assign fade_busy = (state_q == StFade);
`else
  assign fade_busy = 1'b0;
`endif

endmodule

// File: tb/tb_rgb_pwm_dimmer.sv
// Bench for rgb_pwm_dimmer (PWM_W = 4, FADE_STEP = 4). Works with or without PWM_FADE_EN.
module tb_rgb_pwm_dimmer;

  localparam int unsigned W      = 4;
  localparam int unsigned STEP   = 4;
  localparam int          PERIOD = 16;

  logic         clk = 1'b0;
  logic         rstn, en, r_in, g_in, b_in;
  logic [W-1:0] bright;
  logic         r_out, g_out, b_out, fade_busy;

  int checks;
  int errors;

  // Reference model: period-level view of the dimmer.
  int       m_cnt;
  int       m_level;
  logic [2:0] m_rgb;
  bit       m_fade;
  logic [2:0] exp_out;

  int hi_r, hi_g, hi_b;
  bit busy0;

  int exp_t2_g[4];
  int exp_t2_busy[4];
  int exp_t3_g[5];
  int exp_t3_busy[5];

  always #5 clk = ~clk;

  rgb_pwm_dimmer #(
    .PWM_W    (W),
    .FADE_STEP(STEP)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .r_in     (r_in),
    .g_in     (g_in),
    .b_in     (b_in),
    .bright   (bright),
    .r_out    (r_out),
    .g_out    (g_out),
    .b_out    (b_out),
    .fade_busy(fade_busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advances the model by one clock using the inputs the DUT is about to sample.
  task automatic model_edge();
    logic [2:0] nrgb;
    int         nb;
    int         nxt;
    if (!rstn) begin
      m_cnt   = 0;
      m_level = 0;
      m_rgb   = 3'b000;
      m_fade  = 0;
      exp_out = 3'b000;
      return;
    end
    exp_out = (m_cnt < m_level) ? m_rgb : 3'b000;
    if (en) begin
      if (m_cnt == PERIOD - 1) begin
        nrgb = {r_in, g_in, b_in};
        nb   = int'(bright);
        if (nb == 0 || nrgb == 3'b000) begin
          m_level = 0;
          m_fade  = 0;
        end else if (nrgb != m_rgb) begin
`ifdef PWM_FADE_EN
          m_level = 0;
          m_fade  = 1;
`else
          m_level = nb;
          m_fade  = 0;
`endif
        end else if (m_fade) begin
          nxt = m_level + int'(STEP);
          if (nxt > nb) nxt = nb;
          m_level = nxt;
          m_fade  = (nxt != nb);
        end else begin
          m_level = nb;
          m_fade  = 0;
        end
        m_rgb = nrgb;
      end
      m_cnt = (m_cnt + 1) % PERIOD;
    end
  endtask

  task automatic tick();
    model_edge();
    @(negedge clk);
    check_val("rgb_out", {r_out, g_out, b_out}, exp_out);
    check_val("fade_busy", fade_busy, m_fade);
  endtask

  // Aligns to a period start, then counts high samples over one full PWM period.
  task automatic run_period();
    while (m_cnt != 0) tick();
    hi_r = 0;
    hi_g = 0;
    hi_b = 0;
    for (int i = 0; i < PERIOD; i++) begin
      tick();
      if (i == 0) busy0 = fade_busy;
      hi_r += int'(r_out);
      hi_g += int'(g_out);
      hi_b += int'(b_out);
    end
  endtask

  task automatic set_rgb(input logic r, input logic g, input logic b);
    r_in = r;
    g_in = g;
    b_in = b;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    m_cnt   = 0;
    m_level = 0;
    m_rgb   = 3'b000;
    m_fade  = 0;
    exp_out = 3'b000;
`ifdef PWM_FADE_EN
    exp_t2_g    = '{0, 0, 4, 8};
    exp_t2_busy = '{0, 1, 1, 0};
    exp_t3_g    = '{0, 4, 8, 10, 10};
    exp_t3_busy = '{1, 1, 1, 0, 0};
`else
    exp_t2_g    = '{0, 8, 8, 8};
    exp_t2_busy = '{0, 0, 0, 0};
    exp_t3_g    = '{10, 10, 10, 10, 10};
    exp_t3_busy = '{0, 0, 0, 0, 0};
`endif

    // Reset with a lit request pending.
    rstn   = 1'b0;
    en     = 1'b1;
    set_rgb(1'b1, 1'b0, 1'b0);
    bright = 4'd15;
    repeat (3) tick();
    check_val("reset_out", {r_out, g_out, b_out}, 0);
    check_val("reset_busy", fade_busy, 0);
    check_val("reset_cnt", dut.cnt_q, 0);

    // Steady green at half duty.
    rstn   = 1'b1;
    set_rgb(1'b0, 1'b1, 1'b0);
    bright = 4'd8;
    for (int p = 0; p < 4; p++) begin
      run_period();
      check_val("t2_g_high", hi_g, exp_t2_g[p]);
      check_val("t2_rb_high", hi_r + hi_b, 0);
      check_val("t2_busy", busy0, exp_t2_busy[p]);
    end

    // Red at level 10, then a colour change to green.
    set_rgb(1'b1, 1'b0, 1'b0);
    bright = 4'd10;
    repeat (6) run_period();
    set_rgb(1'b0, 1'b1, 1'b0);
    run_period();
    for (int p = 0; p < 5; p++) begin
      run_period();
      check_val("t3_g_high", hi_g, exp_t3_g[p]);
      check_val("t3_r_high", hi_r, 0);
      check_val("t3_busy", busy0, exp_t3_busy[p]);
    end

    // Blue glitch inside a period, gone before the boundary.
    repeat (6) tick();
    b_in = 1'b1;
    repeat (2) tick();
    b_in = 1'b0;
    run_period();
    check_val("t4_g_high", hi_g, 10);
    check_val("t4_b_high", hi_b, 0);
    check_val("t4_busy", busy0, 0);

    // Brightness 12, then dark, then back to 6 without a fade.
    bright = 4'd12;
    run_period();
    run_period();
    check_val("t5_g_high_12", hi_g, 12);
    bright = 4'd0;
    run_period();
    run_period();
    check_val("t5_all_dark", hi_r + hi_g + hi_b, 0);
    bright = 4'd6;
    run_period();
    run_period();
    check_val("t5_g_high_6", hi_g, 6);
    check_val("t5_busy", busy0, 0);

    // Colour change to blue, reset a few ticks into the level-4 period, then hold en low.
    set_rgb(1'b0, 1'b0, 1'b1);
    bright = 4'd15;
    run_period();
    run_period();
    repeat (3) tick();
    rstn = 1'b0;
    tick();
    check_val("t6_reset_out", {r_out, g_out, b_out}, 0);
    check_val("t6_reset_busy", fade_busy, 0);
    rstn = 1'b1;
    en   = 1'b0;
    repeat (20) tick();
    check_val("t6_frozen_cnt", dut.cnt_q, 0);
    check_val("t6_frozen_out", {r_out, g_out, b_out}, 0);

    // Randomised traffic: sparse en, occasional colour/brightness changes and resets.
    for (int i = 0; i < 4000; i++) begin
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 120) == 0) {r_in, g_in, b_in} = 3'($urandom);
      if ($urandom_range(0, 200) == 0) bright = W'($urandom);
      rstn = ($urandom_range(0, 700) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
